// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit.
//   state_t       : main FSM state encoding
//   OP_*          : instruction class (Instr Op field)
//   ALU_*         : ALUControl encodings
//   CMD_*         : data-processing cmd field values (Funct[4:1])
//   COND_*        : condition-code field values
//   cond_check()  : evaluates a condition code against NZCV flags
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // flags = {N, Z, C, V}; the reserved code 1111 never executes.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic res;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_HI: res = c & ~z;
      COND_LS: res = ~(c & ~z);
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = ~z & (n == v);
      COND_LE: res = ~(~z & (n == v));
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between the multicycle controller and its datapath.
//   Instr, ALUFlags           : datapath -> controller
//   PCWrite ... ALUControl    : controller -> datapath
// master = controller side, slave = datapath side.
interface mc_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  ALUControl;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );
endinterface

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds the architectural NZCV flags and
// decides whether the current instruction executes.
//   clk, reset  : clock, synchronous active-high reset (clears flags)
//   cond        : instruction condition field
//   alu_flags   : {N,Z,C,V} from the ALU
//   flag_w      : [1] update NZ, [0] update CV
//   flag_upd    : high during the execute states
//   cond_ex     : condition passes on the stored flags
module cond_unit
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       flag_upd,
  output logic       cond_ex
);

  logic [3:0] flags_r;
  logic       cond_ex_s;

  // Condition evaluation always uses the flags as they stand before this edge.
  always_comb begin
    cond_ex_s = cond_check(cond, flags_r);
  end

  assign cond_ex = cond_ex_s;

  // Flags register: NZ and CV groups update independently, only when executing.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r <= 4'b0000;
    end else if (flag_upd && cond_ex_s) begin
      if (flag_w[1]) begin
        flags_r[3:2] <= alu_flags[3:2];
      end else begin
        flags_r[3:2] <= flags_r[3:2];
      end
      if (flag_w[0]) begin
        flags_r[1:0] <= alu_flags[1:0];
      end else begin
        flags_r[1:0] <= flags_r[1:0];
      end
    end else begin
      flags_r <= flags_r;
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit for the ARM-subset datapath.
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high; aborts the current instruction
//   bus    : mc_controller_if.master -- Instr/ALUFlags in, every datapath
//            enable and mux select out
// Selects are Moore outputs of the main FSM; write enables are gated by
// the condition check. While reset is high all enables are held low and
// the selects show their FETCH values.
module mc_controller
  import mc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  mc_controller_if.master  bus
);

  state_t     state_r;
  state_t     next_state_s;

  logic [3:0] cond_s;
  logic [1:0] op_s;
  logic [5:0] funct_s;
  logic [3:0] rd_s;
  logic [3:0] cmd_s;
  logic       unused_rn_s;

  // Raw per-state controls
  logic       next_pc_s;
  logic       reg_w_s;
  logic       mem_w_s;
  logic       ir_write_s;
  logic       branch_s;
  logic       alu_op_s;
  logic       adr_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] result_src_s;

  // ALU decoder
  logic [1:0] dec_alu_s;
  logic       dec_no_write_s;
  logic       no_write_s;
  logic [1:0] flag_w_s;

  // Gating
  logic       cond_ex_s;
  logic       flag_upd_s;
  logic       pcs_s;
  logic       pc_write_s;
  logic       reg_write_s;
  logic       mem_write_s;
  logic       ir_write_g_s;

  assign cond_s  = bus.Instr[19:16];
  assign op_s    = bus.Instr[15:14];
  assign funct_s = bus.Instr[13:8];
  assign rd_s    = bus.Instr[3:0];
  assign cmd_s   = funct_s[4:1];
  // Rn is a datapath concern only.
  assign unused_rn_s = ^bus.Instr[7:4];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH:  next_state_s = S_DECODE;
      S_DECODE: begin
        case (op_s)
          OP_MEM:  next_state_s = S_MEMADR;
          OP_DP:   next_state_s = funct_s[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   next_state_s = S_BRANCH;
          default: next_state_s = S_FETCH;   // Op=11 behaves as a NOP
        endcase
      end
      S_MEMADR:   next_state_s = funct_s[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state_s = S_MEMWB;
      S_MEMWRITE: next_state_s = S_FETCH;
      S_MEMWB:    next_state_s = S_FETCH;
      S_EXECUTER: next_state_s = S_ALUWB;
      S_EXECUTEI: next_state_s = S_ALUWB;
      S_ALUWB:    next_state_s = S_FETCH;
      S_BRANCH:   next_state_s = S_FETCH;
      default:    next_state_s = S_FETCH;
    endcase
  end

  // Per-state Moore outputs; reset overrides with FETCH selects and no writes.
  always_comb begin
    next_pc_s    = 1'b0;
    reg_w_s      = 1'b0;
    mem_w_s      = 1'b0;
    ir_write_s   = 1'b0;
    branch_s     = 1'b0;
    alu_op_s     = 1'b0;
    adr_src_s    = 1'b0;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    result_src_s = 2'b00;
    if (reset) begin
      alu_src_a_s  = 2'b01;
      alu_src_b_s  = 2'b10;
      result_src_s = 2'b10;
    end else begin
      case (state_r)
        S_FETCH: begin
          ir_write_s   = 1'b1;
          next_pc_s    = 1'b1;
          alu_src_a_s  = 2'b01;
          alu_src_b_s  = 2'b10;
          result_src_s = 2'b10;
        end
        S_DECODE: begin
          alu_src_a_s  = 2'b01;
          alu_src_b_s  = 2'b10;
          result_src_s = 2'b10;
        end
        S_MEMADR: begin
          alu_src_b_s  = 2'b01;
        end
        S_MEMREAD: begin
          adr_src_s    = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src_s    = 1'b1;
          mem_w_s      = 1'b1;
        end
        S_MEMWB: begin
          result_src_s = 2'b01;
          reg_w_s      = 1'b1;
        end
        S_EXECUTER: begin
          alu_op_s     = 1'b1;
        end
        S_EXECUTEI: begin
          alu_src_b_s  = 2'b01;
          alu_op_s     = 1'b1;
        end
        S_ALUWB: begin
          reg_w_s      = 1'b1;
        end
        S_BRANCH: begin
          alu_src_b_s  = 2'b01;
          result_src_s = 2'b10;
          branch_s     = 1'b1;
        end
        default: begin
          next_pc_s    = 1'b0;
        end
      endcase
    end
  end

  // ALU decoder. NoWrite comes straight from Instr so it still suppresses
  // the write in ALUWB; it only applies to data-processing instructions.
  always_comb begin
    dec_alu_s      = ALU_ADD;
    dec_no_write_s = 1'b1;
    case (cmd_s)
      CMD_ADD: begin dec_alu_s = ALU_ADD; dec_no_write_s = 1'b0; end
      CMD_SUB: begin dec_alu_s = ALU_SUB; dec_no_write_s = 1'b0; end
      CMD_AND: begin dec_alu_s = ALU_AND; dec_no_write_s = 1'b0; end
      CMD_ORR: begin dec_alu_s = ALU_ORR; dec_no_write_s = 1'b0; end
      CMD_CMP: begin dec_alu_s = ALU_SUB; dec_no_write_s = 1'b1; end
      default: begin dec_alu_s = ALU_ADD; dec_no_write_s = 1'b1; end
    endcase
  end

  assign no_write_s = dec_no_write_s & (op_s == OP_DP);
  assign flag_w_s   = {funct_s[0],
                       funct_s[0] & ((cmd_s == CMD_ADD) | (cmd_s == CMD_SUB) | (cmd_s == CMD_CMP))};
  assign flag_upd_s = (state_r == S_EXECUTER) | (state_r == S_EXECUTEI);

  cond_unit u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond_s),
    .alu_flags (bus.ALUFlags),
    .flag_w    (flag_w_s),
    .flag_upd  (flag_upd_s),
    .cond_ex   (cond_ex_s)
  );

  // Write-enable gating; a write to R15 is a PC write.
  always_comb begin
    pcs_s = ((rd_s == 4'hF) & reg_w_s) | branch_s;
    if (reset) begin
      pc_write_s   = 1'b0;
      reg_write_s  = 1'b0;
      mem_write_s  = 1'b0;
      ir_write_g_s = 1'b0;
    end else begin
      pc_write_s   = next_pc_s | (pcs_s & cond_ex_s);
      reg_write_s  = reg_w_s & cond_ex_s & ~no_write_s;
      mem_write_s  = mem_w_s & cond_ex_s;
      ir_write_g_s = ir_write_s;
    end
  end

  assign bus.PCWrite    = pc_write_s;
  assign bus.MemWrite   = mem_write_s;
  assign bus.RegWrite   = reg_write_s;
  assign bus.IRWrite    = ir_write_g_s;
  assign bus.AdrSrc     = adr_src_s;
  assign bus.RegSrc     = {(op_s == OP_MEM), (op_s == OP_BR)};
  assign bus.ALUSrcA    = alu_src_a_s;
  assign bus.ALUSrcB    = alu_src_b_s;
  assign bus.ResultSrc  = result_src_s;
  assign bus.ImmSrc     = op_s;
  assign bus.ALUControl = alu_op_s ? dec_alu_s : ALU_ADD;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: a per-cycle vector table of
// inputs and expected controls/flags, applied through a scoreboard queue,
// plus hand-written NOP and never-condition sequences.
module tb_mc_controller;

  typedef struct {
    logic        rst;
    logic [19:0] instr;
    logic [3:0]  aluf;
    logic [3:0]  en;      // {PCWrite, MemWrite, RegWrite, IRWrite}
    logic        adr;
    logic [1:0]  rs;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [1:0]  res;
    logic [1:0]  imm;
    logic [1:0]  alu;
    logic [3:0]  flags;
  } vec_t;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;
  vec_t vecs[44];
  vec_t sb_q[$];

  mc_controller_if bus_if ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mkv(input logic rst, input logic [19:0] instr, input logic [3:0] aluf,
                               input logic [3:0] en, input logic adr, input logic [1:0] rs,
                               input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] res,
                               input logic [1:0] imm, input logic [1:0] alu, input logic [3:0] flags);
    vec_t v;
    v.rst = rst; v.instr = instr; v.aluf = aluf; v.en = en; v.adr = adr; v.rs = rs;
    v.sa = sa; v.sb = sb; v.res = res; v.imm = imm; v.alu = alu; v.flags = flags;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then compare shortly after.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    logic [16:0] act_ctl;
    logic [16:0] exp_ctl;
    @(negedge clk);
    reset = v.rst;
    bus_if.Instr = v.instr;
    bus_if.ALUFlags = v.aluf;
    sb_q.push_back(v);
    #1;
    e = sb_q.pop_front();
    act_ctl = {bus_if.PCWrite, bus_if.MemWrite, bus_if.RegWrite, bus_if.IRWrite, bus_if.AdrSrc,
               bus_if.RegSrc, bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.ResultSrc, bus_if.ImmSrc,
               bus_if.ALUControl};
    exp_ctl = {e.en, e.adr, e.rs, e.sa, e.sb, e.res, e.imm, e.alu};
    check("controls", idx, {15'd0, act_ctl}, {15'd0, exp_ctl});
    check("flags", idx, {28'd0, dut.u_cond.flags_r}, {28'd0, e.flags});
  endtask

  initial begin
    int n;
    logic seen;
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1;
    bus_if.Instr = 20'hE0821;
    bus_if.ALUFlags = 4'h0;
    repeat (3) @(posedge clk);

    //                rst   instr     aluf  en       adr   rs     sa     sb     res    imm    alu    flags
    vecs[0]  = mkv(1'b1, 20'hE0821, 4'hF, 4'b0000, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 4'h0); // reset
    vecs[1]  = mkv(1'b0, 20'hE0821, 4'hF, 4'b1001, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 4'h0); // ADD fetch
    vecs[2]  = mkv(1'b0, 20'hE0821, 4'hF, 4'b0000, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 4'h0); // decode
    vecs[3]  = mkv(1'b0, 20'hE0821, 4'hF, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0); // executer
    vecs[4]  = mkv(1'b0, 20'hE0821, 4'hF, 4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0); // aluwb
    vecs[5]  = mkv(1'b0, 20'hE5912, 4'hF, 4'b1001, 1'b0, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 4'h0); // LDR fetch
    vecs[6]  = mkv(1'b0, 20'hE5912, 4'hF, 4'b0000, 1'b0, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 4'h0); // decode
    vecs[7]  = mkv(1'b0, 20'hE5912, 4'hF, 4'b0000, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 4'h0); // memadr
    vecs[8]  = mkv(1'b0, 20'hE5912, 4'hF, 4'b0000, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 4'h0); // memread
    vecs[9]  = mkv(1'b0, 20'hE5912, 4'hF, 4'b0010, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 4'h0); // memwb
    vecs[10] = mkv(1'b0, 20'hE5812, 4'hF, 4'b1001, 1'b0, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 4'h0); // STR fetch
    vecs[11] = mkv(1'b0, 20'hE5812, 4'hF, 4'b0000, 1'b0, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 4'h0); // decode
    vecs[12] = mkv(1'b0, 20'hE5812, 4'hF, 4'b0000, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 4'h0); // memadr
    vecs[13] = mkv(1'b0, 20'hE5812, 4'hF, 4'b0100, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 4'h0); // memwrite
    vecs[14] = mkv(1'b0, 20'hE2500, 4'h4, 4'b1001, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 4'h0); // SUBS fetch
    vecs[15] = mkv(1'b0, 20'hE2500, 4'h4, 4'b0000, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 4'h0); // decode
    vecs[16] = mkv(1'b0, 20'hE2500, 4'h4, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 4'h0); // executei
    vecs[17] = mkv(1'b0, 20'hE2500, 4'h4, 4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h4); // aluwb
    vecs[18] = mkv(1'b0, 20'h0A000, 4'h0, 4'b1001, 1'b0, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 4'h4); // BEQ fetch
    vecs[19] = mkv(1'b0, 20'h0A000, 4'h0, 4'b0000, 1'b0, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 4'h4); // decode
    vecs[20] = mkv(1'b0, 20'h0A000, 4'h0, 4'b1000, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 4'h4); // branch taken
    vecs[21] = mkv(1'b0, 20'h1A000, 4'h0, 4'b1001, 1'b0, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 4'h4); // BNE fetch
    vecs[22] = mkv(1'b0, 20'h1A000, 4'h0, 4'b0000, 1'b0, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 4'h4); // decode
    vecs[23] = mkv(1'b0, 20'h1A000, 4'h0, 4'b0000, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 4'h4); // not taken
    vecs[24] = mkv(1'b0, 20'h10821, 4'hF, 4'b1001, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 4'h4); // ADDNE fetch
    vecs[25] = mkv(1'b0, 20'h10821, 4'hF, 4'b0000, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 4'h4); // decode
    vecs[26] = mkv(1'b0, 20'h10821, 4'hF, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h4); // executer
    vecs[27] = mkv(1'b0, 20'h10821, 4'hF, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h4); // aluwb no write
    vecs[28] = mkv(1'b0, 20'hE1500, 4'h8, 4'b1001, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 4'h4); // CMP fetch
    vecs[29] = mkv(1'b0, 20'hE1500, 4'h8, 4'b0000, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 4'h4); // decode
    vecs[30] = mkv(1'b0, 20'hE1500, 4'h8, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 4'h4); // executer
    vecs[31] = mkv(1'b0, 20'hE1500, 4'h8, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h8); // aluwb
    vecs[32] = mkv(1'b0, 20'hE082F, 4'h0, 4'b1001, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 4'h8); // ADD PC fetch
    vecs[33] = mkv(1'b0, 20'hE082F, 4'h0, 4'b0000, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 4'h8); // decode
    vecs[34] = mkv(1'b0, 20'hE082F, 4'h0, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h8); // executer
    vecs[35] = mkv(1'b0, 20'hE082F, 4'h0, 4'b1010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h8); // aluwb R15
    vecs[36] = mkv(1'b0, 20'hE5912, 4'h0, 4'b1001, 1'b0, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 4'h8); // LDR fetch
    vecs[37] = mkv(1'b0, 20'hE5912, 4'h0, 4'b0000, 1'b0, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 4'h8); // decode
    vecs[38] = mkv(1'b0, 20'hE5912, 4'h0, 4'b0000, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 4'h8); // memadr
    vecs[39] = mkv(1'b1, 20'hE5912, 4'h0, 4'b0000, 1'b0, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 4'h8); // reset in memread
    vecs[40] = mkv(1'b1, 20'hE5912, 4'h0, 4'b0000, 1'b0, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 4'h0); // reset held
    vecs[41] = mkv(1'b0, 20'h0A000, 4'h0, 4'b1001, 1'b0, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 4'h0); // BEQ fetch
    vecs[42] = mkv(1'b0, 20'h0A000, 4'h0, 4'b0000, 1'b0, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 4'h0); // decode
    vecs[43] = mkv(1'b0, 20'h0A000, 4'h0, 4'b0000, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 4'h0); // Z clear: no branch

    for (int i = 0; i < 44; i++) begin
      step(vecs[i], i);
    end

    // NOP (Op=11): FETCH, DECODE, then straight back to FETCH.
    step(mkv(1'b0, 20'hEC000, 4'h0, 4'b1001, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 4'h0), 100);
    n = 0;
    seen = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      if (!seen && bus_if.IRWrite) begin
        seen = 1'b1;
        n = k;
      end
    end
    if (!seen) begin
      total_cnt++;
      $display("FAIL nop_refetch: no IRWrite within 6 cycles, expected after 2");
    end else begin
      check("nop_refetch_cycles", 101, n, 32'd2);
    end

    // Reserved condition 1111 never writes; resync from a known FETCH first.
    step(mkv(1'b1, 20'hF0821, 4'h0, 4'b0000, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 4'h0), 110);
    step(mkv(1'b0, 20'hF0821, 4'h0, 4'b1001, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 4'h0), 111);
    step(mkv(1'b0, 20'hF0821, 4'h0, 4'b0000, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 4'h0), 112);
    step(mkv(1'b0, 20'hF0821, 4'h0, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0), 113);
    step(mkv(1'b0, 20'hF0821, 4'h0, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0), 114);
    step(mkv(1'b0, 20'hE0821, 4'h0, 4'b1001, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 4'h0), 115);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
